// File: rtl/line_buffer_nline.sv
// Multi-line video buffer: keeps NUM_LINES previous lines in inferred RAMs and
// presents the co-located pixels of those lines alongside each accepted pixel.
module line_buffer_nline #(
  parameter int DATA_W      = 8,
  parameter int LINE_MAX    = 1024,
  parameter int ADDR_W      = 10,
  parameter int NUM_LINES   = 2,
  parameter int BORDER_MODE = 0
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          per_frame_vsync,
  input  logic                          per_frame_href,
  input  logic                          clken,
  input  logic [DATA_W-1:0]             shiftin,
  output logic [DATA_W-1:0]             pix_out,
  output logic [NUM_LINES*DATA_W-1:0]   taps,
  output logic                          tap_valid,
  output logic [2:0]                    line_cnt,
  output logic                          ovf
);

  localparam int CW = ADDR_W + 1;

  logic                               accept, at_max, href_d;
  logic [CW-1:0]                      col;
  logic                               wr_en;
  logic [ADDR_W-1:0]                  wr_addr;
  logic [2:0]                         mask_cnt;
  logic                               mask_ovf;
  logic [NUM_LINES-1:0][DATA_W-1:0]   rd_all;
  logic [DATA_W-1:0]                  repl;

  assign accept = per_frame_href & clken;
  assign at_max = (col == CW'(LINE_MAX));

  // Read at accept, write one cycle later; RAMk takes the old word of RAM(k-1).
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    logic [DATA_W-1:0] mem [LINE_MAX];
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wdata;

    if (k == 0) begin : g_head
      assign wdata = pix_out;
    end else begin : g_tail
      assign wdata = rd_all[k-1];
    end

    always_ff @(posedge clock) begin
      if (accept && !at_max) rd <= mem[col[ADDR_W-1:0]];
      if (wr_en) mem[wr_addr] <= wdata;
    end

    assign rd_all[k] = rd;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      href_d    <= 1'b0;
      line_cnt  <= '0;
      ovf       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      pix_out   <= '0;
      tap_valid <= 1'b0;
      mask_cnt  <= '0;
      mask_ovf  <= 1'b0;
    end else begin
      href_d    <= per_frame_href;
      tap_valid <= accept;
      wr_en     <= accept && !at_max;
      if (accept) begin
        pix_out  <= shiftin;
        wr_addr  <= col[ADDR_W-1:0];
        // vsync in the accept cycle already counts as a cleared frame
        mask_cnt <= per_frame_vsync ? 3'd0 : line_cnt;
        mask_ovf <= at_max;
      end
      if (!per_frame_href)        col <= '0;
      else if (accept && !at_max) col <= col + CW'(1);
      if (per_frame_vsync)
        line_cnt <= '0;
      else if (href_d && !per_frame_href && line_cnt != 3'(NUM_LINES))
        line_cnt <= line_cnt + 3'd1;
      if (per_frame_vsync)        ovf <= 1'b0;
      else if (accept && at_max)  ovf <= 1'b1;
    end
  end

  // Nearest valid line for replication; the current pixel when none exists yet.
  always_comb begin
    repl = pix_out;
    for (int j = 0; j < NUM_LINES; j++)
      if (mask_cnt == 3'(j + 1)) repl = rd_all[j];
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (mask_ovf)                taps[k*DATA_W +: DATA_W] = '0;
      else if (mask_cnt > 3'(k))   taps[k*DATA_W +: DATA_W] = rd_all[k];
      else if (BORDER_MODE != 0)   taps[k*DATA_W +: DATA_W] = repl;
    end
  end

endmodule

// File: tb/tb_line_buffer_nline.sv
// Bench for line_buffer_nline: three configurations share one stimulus stream and
// are compared every cycle against a per-column pixel-history model.
module tb_line_buffer_nline;
  localparam int ND = 3;

  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0] pix = 8'h00;

  logic [ND-1:0][7:0]  po;
  logic [ND-1:0][31:0] tp;
  logic [ND-1:0]       tv, ov;
  logic [ND-1:0][2:0]  lc;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign tp[0][31:16] = '0;
  assign tp[1][31:16] = '0;
  assign tp[2][31:24] = '0;

  line_buffer_nline #(.DATA_W(8), .LINE_MAX(16), .ADDR_W(4), .NUM_LINES(2), .BORDER_MODE(0)) dut0 (
    .clock(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href), .clken(clken),
    .shiftin(pix), .pix_out(po[0]), .taps(tp[0][15:0]), .tap_valid(tv[0]), .line_cnt(lc[0]), .ovf(ov[0]));
  line_buffer_nline #(.DATA_W(8), .LINE_MAX(16), .ADDR_W(4), .NUM_LINES(2), .BORDER_MODE(1)) dut1 (
    .clock(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href), .clken(clken),
    .shiftin(pix), .pix_out(po[1]), .taps(tp[1][15:0]), .tap_valid(tv[1]), .line_cnt(lc[1]), .ovf(ov[1]));
  line_buffer_nline #(.DATA_W(8), .LINE_MAX(8), .ADDR_W(3), .NUM_LINES(3), .BORDER_MODE(0)) dut2 (
    .clock(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href), .clken(clken),
    .shiftin(pix), .pix_out(po[2]), .taps(tp[2][23:0]), .tap_valid(tv[2]), .line_cnt(lc[2]), .ovf(ov[2]));

  function automatic int bm_of(int d);   return (d == 1) ? 1 : 0;  endfunction
  function automatic int lmax_of(int d); return (d == 2) ? 8 : 16; endfunction
  function automatic int nl_of(int d);   return (d == 2) ? 3 : 2;  endfunction

  // Model: hist[d][c] lists the pixels written at column c, most recent first.
  int         hist [ND][16][$];
  int         cnt [ND], col [ND];
  bit         ovfm [ND];
  bit         hprev, ev;
  logic [7:0] epix;
  logic [7:0] etap [ND][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      cnt[d] = 0; col[d] = 0; ovfm[d] = 0;
    end
    hprev = 0; ev = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = href & clken;
    ev = acc;
    if (acc) epix = pix;
    for (int d = 0; d < ND; d++) begin
      int eff;
      eff = vsync ? 0 : cnt[d];
      if (acc) begin
        for (int k = 0; k < nl_of(d); k++) begin
          if (col[d] == lmax_of(d))  etap[d][k] = 8'h00;
          else if (eff > k)          etap[d][k] = 8'(hist[d][col[d]][k]);
          else if (bm_of(d) == 0)    etap[d][k] = 8'h00;
          else if (eff > 0)          etap[d][k] = 8'(hist[d][col[d]][eff-1]);
          else                       etap[d][k] = pix;
        end
        if (col[d] < lmax_of(d)) begin
          hist[d][col[d]].push_front(int'(pix));
          if (hist[d][col[d]].size() > 4) void'(hist[d][col[d]].pop_back());
          col[d]++;
        end else ovfm[d] = 1;
      end
      if (!href) col[d] = 0;
      if (vsync) begin
        cnt[d] = 0; ovfm[d] = 0;
      end else if (hprev && !href && cnt[d] < nl_of(d)) cnt[d]++;
    end
    hprev = href;
  endtask

  task automatic compare();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d tap_valid", d), 32'(tv[d]), 32'(ev));
      check($sformatf("d%0d line_cnt", d), 32'(lc[d]), 32'(cnt[d]));
      check($sformatf("d%0d ovf", d), 32'(ov[d]), 32'(ovfm[d]));
      if (ev) begin
        check($sformatf("d%0d pix_out", d), 32'(po[d]), 32'(epix));
        for (int k = 0; k < nl_of(d); k++)
          check($sformatf("d%0d tap%0d", d, k), 32'(tp[d][k*8 +: 8]), 32'(etap[d][k]));
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge, sample at the next fall.
  task automatic step(input bit vs, input bit hr, input bit ce, input logic [7:0] px);
    vsync = vs; href = hr; clken = ce; pix = px;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic check_zero_outputs(input string ph);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s d%0d pix_out", ph, d), 32'(po[d]), 32'h0);
      check($sformatf("%s d%0d taps", ph, d), tp[d], 32'h0);
      check($sformatf("%s d%0d tap_valid", ph, d), 32'(tv[d]), 32'h0);
      check($sformatf("%s d%0d line_cnt", ph, d), 32'(lc[d]), 32'h0);
      check($sformatf("%s d%0d ovf", ph, d), 32'(ov[d]), 32'h0);
    end
  endtask

  task automatic ramp_frame();
    step(1, 0, 0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 8; c++) begin
        step(0, 1, 1, 8'(16 * l + c));
        if (l == 2 && c == 5) begin
          check("ramp l2c5 tap0", 32'(tp[0][7:0]), 32'h15);
          check("ramp l2c5 tap1", 32'(tp[0][15:8]), 32'h05);
        end
        if (l == 0 && c == 3) begin
          check("repl l0c3 tap0", 32'(tp[1][7:0]), 32'h03);
          check("repl l0c3 tap1", 32'(tp[1][15:8]), 32'h03);
          check("repl l0c3 pix_out", 32'(po[1]), 32'h03);
        end
        if (l == 1 && c == 3) begin
          check("repl l1c3 tap0", 32'(tp[1][7:0]), 32'h03);
          check("repl l1c3 tap1", 32'(tp[1][15:8]), 32'h03);
        end
      end
      step(0, 0, 0, 8'h00);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ramp_frame();

    // Sparse clken with random gaps, ignored clken during href low, occasional vsync mid-line.
    step(1, 0, 0, 8'h00);
    for (int l = 0; l < 8; l++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        repeat ($urandom_range(1, 3)) step(0, 1, 0, 8'($urandom));
        step($urandom_range(0, 11) == 0, 1, 1, 8'($urandom));
      end
      repeat ($urandom_range(1, 2)) step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Overflow on the 8-pixel configuration with a 10-pixel line.
    step(1, 0, 0, 8'h00);
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 1, 8'(8'h80 + c));
      if (c == 7) check("ovf before pixel 9", 32'(ov[2]), 32'h0);
      if (c >= 8) begin
        check("ovf at pixel 9+", 32'(ov[2]), 32'h1);
        check("ovf taps zero", tp[2], 32'h0);
      end
    end
    step(0, 0, 0, 8'h00);
    for (int c = 0; c < 8; c++) step(0, 1, 1, 8'(8'hA0 + c));
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("ovf cleared by vsync", 32'(ov[2]), 32'h0);

    // vsync coincident with the href falling edge.
    for (int c = 0; c < 6; c++) step(0, 1, 1, 8'(8'hC0 + c));
    step(1, 0, 0, 8'h00);
    check("vsync wins line_cnt", 32'(lc[0]), 32'h0);
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 1, 8'(8'hD0 + c));
      if (c == 0) check("vsync wins tap masked", tp[0], 32'h0);
    end
    step(0, 0, 0, 8'h00);

    // Mid-line reset after an idle cycle, then a fresh ramp frame.
    for (int c = 0; c < 5; c++) step(0, 1, 1, 8'(8'hE0 + c));
    step(0, 1, 0, 8'h00);
    rst_n = 1'b0; href = 1'b0; clken = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ramp_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_nline.md
# line_buffer_nline

Parametrised multi-line buffer for streaming pixel video: it stores up to NUM_LINES previous lines and presents, for every accepted pixel, the co-located pixels of those lines plus a delayed copy of the current pixel. It feeds the 3x3 and 5x5 window generators in the image-processing pipeline between the camera capture block and the filter/edge stages. The block adds per-frame line counting, configurable top-border handling and line-length overflow detection. It uses inferred RAM only, with no vendor IP.

## Interface
- DATA_W, 8: pixel width in bits.
- LINE_MAX, 1024: maximum pixels per line (RAM depth per line).
- ADDR_W, 10: column address width; must satisfy 2**ADDR_W >= LINE_MAX.
- NUM_LINES, 2: number of previous lines output; legal range 1..4.
- BORDER_MODE, 0: 0 = zero-fill taps for lines not yet received in this frame; 1 = replicate nearest valid line.

- clock  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- per_frame_vsync  in  1  frame sync; high clears the line count.
- per_frame_href  in  1  line active; its falling edge ends a line.
- clken  in  1  pixel strobe; a pixel is accepted when href & clken.
- shiftin  in  DATA_W  current pixel.
- pix_out  out  DATA_W  accepted pixel, delayed 1 cycle.
- taps  out  NUM_LINES*DATA_W  previous-line pixels; slice k (LSB first) holds line n-1-k.
- tap_valid  out  1  high 1 cycle after each accepted pixel.
- line_cnt  out  3  lines completed this frame, saturating at NUM_LINES.
- ovf  out  1  sticky; a line exceeded LINE_MAX pixels this frame.

## Operation
- **Column counter col.** Increments on each accepted pixel. Clears when href is low.
- **Line RAMs.** One RAM per line, each LINE_MAX x DATA_W. For an accept at column c:
  - Read all RAMs at address c.
  - The next cycle, write RAM0[c] <= pixel and RAMk[c] <= old RAM(k-1)[c] (read-before-write cascade).
- **Line end.** On the href falling edge (href registered 1, now 0), line_cnt increments, saturating at NUM_LINES.
- **Frame start.** vsync high forces line_cnt = 0 and ovf = 0. RAM contents are not cleared; stale data is masked using line_cnt.
- **Tap masking.** Tap k is valid when line_cnt > k. For an invalid tap:
  - BORDER_MODE 0: output 0.
  - BORDER_MODE 1: output valid tap j, where j is the largest index below k; if no tap is valid, output pix_out.
- **Overflow.** An accept with col == LINE_MAX:
  - No RAM write occurs and col holds.
  - taps output 0 for that pixel; tap_valid still pulses.
  - ovf is set until the next vsync.
- **Ignored inputs.** clken with href low is ignored: no tap_valid and no write.
- **Simultaneous events.**
  - vsync high in the same cycle as an href falling edge: vsync wins, line_cnt = 0.
  - vsync with href high: pixels are still accepted and written, and masking uses the cleared line_cnt.

## Timing
- **Reset values.** pix_out = 0, taps = 0, tap_valid = 0, line_cnt = 0, ovf = 0. Internal col and delay registers also reset to 0.
- **Latency.** An accept in cycle t produces pix_out, taps and tap_valid registered in cycle t+1.
- **Throughput.** Back-to-back accepts (clken high every cycle) are supported at full rate. Consecutive accepts always hit different addresses, so there is no read/write hazard.
- **Line boundary.** An href falling edge in cycle t updates line_cnt in cycle t+1. A pixel accepted in cycle t+1 or later sees the new masking.
  - Minimum href-low gap between lines: 1 cycle.
- **Reset mid-line.** All registers return to reset values immediately. The next frame must start with vsync; taps stay masked because line_cnt = 0.

## Test plan
- **Ramp, 3 lines.** Reset; vsync pulse; 3 lines of 8 pixels, value = 16*line + col, clken always high, NUM_LINES=2, BORDER_MODE=0. Required response:
  - Line 0: taps all 0.
  - Line 1: tap0 = col, tap1 = 0.
  - Line 2, col 5: tap0 = 0x15, tap1 = 0x05.
  - tap_valid exactly 1 cycle after each accept.
- **Replicate border.** BORDER_MODE=1, same stimulus.
  - Line 0, col 3: tap0 = tap1 = pix_out = 0x03.
  - Line 1, col 3: tap1 = tap0 = 0x03.
- **Sparse clken.** Sparse clken (1 of 3 cycles) with random gaps. Taps must match a reference model pixel-for-pixel; no tap_valid while clken is low.
- **Overflow.** LINE_MAX=8, drive a 10-pixel line.
  - ovf rises on the accept of pixel 9.
  - Taps are 0 for pixels 9–10.
  - The next line's taps for cols 0–7 are correct.
  - ovf clears on vsync.
- **vsync wins.** vsync coincident with an href falling edge gives line_cnt = 0. The next frame's line 0 taps are masked even though the RAMs hold old data.
- **Mid-line reset.** Assert rst_n low mid-line: all outputs go to 0 asynchronously. After release and vsync, a fresh 3-line frame reproduces the first scenario's values.
